dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder for the multi-cycle MIPS core: the target end of the memory-access interface that the control FSM and datapath drive during the MEM state. It accepts one word read or write per request and holds an internal word array. It inserts a programmable number of wait states and returns a one-cycle acknowledge with read data or an error flag. The core's MEM state holds until `ack` instead of assuming single-cycle memory.

## Interface
- `ADDR_W`, default 10: word-address bits; the array holds 2^ADDR_W 32-bit words.
- `WAIT`, default 2: wait states inserted before the access; legal range 0..15.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low; sampled on the `clk` rising edge.
- `req`  in  1  request level; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; captured with `req`.
- `addr`  in  32  byte address; captured with `req`.
- `wdata`  in  32  write data; captured with `req`.
- `be`  in  4  byte enables for writes; `be[i]` controls byte lane `[8i+7:8i]`; captured with `req`.
- `rdata`  out  32  read data; valid while `ack`=1.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  error qualifier; valid only while `ack`=1.
- `busy`  out  1  1 whenever the state is not IDLE.

## Operation
- State machine has three states: IDLE, WAIT, RESP. A 4-bit wait counter `cnt` runs alongside it.
- **IDLE**
  - On `req`=1: capture `we`, `addr`, `wdata`, `be`; load `cnt`=WAIT; go to WAIT.
  - On `req`=0: stay in IDLE.
- **WAIT**
  - If `cnt`≠0: `cnt`←`cnt`-1.
  - If `cnt`=0: perform the access on this edge, register the result, go to RESP.
- **RESP**
  - `ack`=1 for exactly this cycle; `rdata`/`err` are valid.
  - Unconditionally go to IDLE.
- **Error check** (on the captured address, evaluated at the access edge):
  - Misaligned: `addr[1:0]`≠0.
  - Out of range: `addr[31:ADDR_W+2]`≠0.
  - On error: no array write, `rdata`=0, `err`=1.
- **Write access** (no error):
  - Update only the lanes whose `be` bit is set.
  - `be`=0 is a legal no-op write: ack with `err`=0.
  - `rdata`=0 on writes.
- **Read access** (no error):
  - `rdata`=full word at `addr[ADDR_W+1:2]`; `be` is ignored.
- `req`, `we`, `addr`, `wdata`, `be` are ignored outside IDLE. Changing inputs mid-transaction has no effect.
- `req` held high through the `ack` cycle starts a new transaction on the first IDLE edge that follows. The requester drops `req` in the `ack` cycle to avoid this.
- Reset drives: state IDLE, `cnt`=0, `ack`=0, `err`=0, `rdata`=0, `busy`=0. Array contents are not reset.

## Timing
- Edge E0 samples `req`=1 in IDLE.
  - The access happens at edge E0+WAIT+1.
  - `ack` is high in the cycle after E0+WAIT+1, i.e. WAIT+1 cycles after the sampling edge.
- With WAIT=0: WAIT state lasts one cycle and `ack` follows on the next cycle.
- `busy` rises in the cycle after E0 and falls in the cycle after the `ack` cycle.
- Throughput with `req` held high: one transaction per WAIT+3 cycles (one IDLE, WAIT+1 in WAIT, one in RESP).
- Read-after-write to the same word in consecutive transactions returns the new data; no bypass is needed.
- **Reset mid-operation**: `rst`=0 on any edge returns to IDLE on that edge.
  - A write whose access edge coincides with or follows that reset edge is not performed.
  - No `ack` is issued for the aborted transaction.
- **Simultaneous events**: reset beats everything. There is no other simultaneous event, because inputs are not sampled outside IDLE.

## Test plan
- **Write then read, WAIT=2**
  - Stimulus: write `addr`=0x10, `wdata`=0xDEADBEEF, `be`=4'hF; then read 0x10.
  - Required: each `ack` exactly 3 cycles after its sampling edge; read `rdata`=0xDEADBEEF, `err`=0.
- **Byte enables**
  - Stimulus: word 0x20 holds 0x11223344; write `wdata`=0xAABBCCDD with `be`=4'b0101; read 0x20.
  - Required: `rdata`=0x11BB33DD.
- **Errors**
  - Stimulus: write to `addr`=0x22 (misaligned); then read `addr`=0x00001000 with ADDR_W=10 (out of range).
  - Required: both `ack` with `err`=1, `rdata`=0; word 0x20 unchanged.
- **Reset mid-transaction**
  - Stimulus: write 0xCAFEF00D to 0x30 (previously 0x0); drive `rst`=0 one cycle after `req` is sampled.
  - Required: no `ack`; `busy`=0 after the reset edge; a later read of 0x30 returns 0x0.
- **Back-to-back, WAIT=0**
  - Stimulus: hold `req`=1 with read to 0x10 across two transactions.
  - Required: `ack` pulses exactly 3 cycles apart; `busy` low for exactly one cycle between them.
- **Input change while busy**
  - Stimulus: change `addr`/`wdata` during WAIT.
  - Required: the access uses the values captured in IDLE.

Source files
------------

// File: rtl/dmem_resp.sv
// ---------------------------------------------------------------------------
// dmem_resp
//
// Data-memory responder for the multi-cycle MIPS core. This is the target end
// of the MEM-state access interface. Each request is one 32-bit word read or
// write against an internal word array. The block inserts WAIT wait states,
// then returns a one-cycle acknowledge carrying read data or an error flag.
//
// Handshake: the requester raises req. req and the request fields (we, addr,
// wdata, be) are sampled only while busy=0, and are captured on that edge.
// From the next cycle the block is busy and ignores every input except rst.
// Exactly WAIT+1 cycles after the sampling edge, ack is high for one cycle and
// rdata/err are valid. busy drops in the cycle after ack. A requester that
// keeps req high through the ack cycle starts another transaction on the
// first idle edge that follows.
//
// Parameters:
//   ADDR_W  word-address bits; the array holds 2**ADDR_W 32-bit words
//   WAIT    wait states inserted before the access, 0..15
//
// Ports:
//   clk    in   clock; all state changes on the rising edge
//   rst    in   synchronous active-low reset
//   req    in   request level, sampled only in IDLE
//   we     in   1 = write, 0 = read
//   addr   in   32-bit byte address
//   wdata  in   write data
//   be     in   byte enables for writes; be[i] controls wdata[8i+7:8i]
//   rdata  out  read data, valid while ack=1 (0 on writes and errors)
//   ack    out  one-cycle completion pulse
//   err    out  misaligned or out-of-range access, valid while ack=1
//   busy   out  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module dmem_resp #(
   parameter int ADDR_W = 10,
   parameter int WAIT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        err,
   output logic        busy
);

   localparam logic [3:0] WAIT_CNT = 4'(WAIT);

   // FSM state is a named enum signal so checkers can bind to it directly.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [3:0]         cnt;

   // Request captured in IDLE; later input changes cannot disturb the access.
   logic               we_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic [3:0]         be_q;

   logic               access;
   logic               acc_err;
   logic [ADDR_W-1:0]  idx;

   logic [31:0]        mem [2**ADDR_W];

   // The access edge is the last edge spent in WAIT.
   assign access  = (state == S_WAIT) && (cnt == 4'd0);

   // Misaligned, or any byte-address bit above the array span is set.
   assign acc_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0);

   assign idx     = addr_q[ADDR_W+1:2];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req) state_nxt = S_WAIT;
         S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ack  = 1'b0;
      busy = 1'b0;
      if (state == S_RESP) ack = 1'b1;
      if (state != S_IDLE) busy = 1'b1;
   end

   // ---------------- request capture and wait counter ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
      end else if ((state == S_IDLE) && req) begin
         cnt     <= WAIT_CNT;
         we_q    <= we;
         addr_q  <= addr;
         wdata_q <= wdata;
         be_q    <= be;
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   // ---------------- response registers ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata <= 32'd0;
         err   <= 1'b0;
      end else if (access) begin
         err   <= acc_err;
         rdata <= (acc_err || we_q) ? 32'd0 : mem[idx];
      end
   end

   // ---------------- word array ----------------
   // No reset on contents. A reset on the access edge must still block the
   // write, hence the rst term in the enable.
   always_ff @(posedge clk) begin
      if (rst && access && we_q && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// ---------------------------------------------------------------------------
// tb_dmem_resp
//
// Two responders side by side: dut 0 with WAIT=2 and dut 1 with WAIT=0.
// The reference model works at transaction level. It numbers the clock edges
// and records the edge that accepted each request. The access is placed at
// start+WAIT+1 and the return to idle at start+WAIT+2. Memory is a plain word
// array with per-byte "known" flags, so unwritten bytes are never compared.
// Expected responses go through a queue that the per-cycle compare process
// drains. Directed transactions add literal expectations on top of the model.
// ---------------------------------------------------------------------------
module tb_dmem_resp;

   localparam int AW = 10;
   localparam int WV [2] = '{2, 0};

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [2];
   logic        req   [2];
   logic        we    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [3:0]  be    [2];
   logic [31:0] rdata [2];
   logic        ack   [2];
   logic        err   [2];
   logic        busy  [2];

   dmem_resp #(.ADDR_W(AW), .WAIT(2)) u_dut_w2 (
      .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
      .wdata(wdata[0]), .be(be[0]), .rdata(rdata[0]), .ack(ack[0]),
      .err(err[0]), .busy(busy[0])
   );

   dmem_resp #(.ADDR_W(AW), .WAIT(0)) u_dut_w0 (
      .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
      .wdata(wdata[1]), .be(be[1]), .rdata(rdata[1]), .ack(ack[1]),
      .err(err[1]), .busy(busy[1])
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int          e = 0;
   bit          started = 1'b0;
   bit          m_pend [2];
   int          m_s    [2];
   bit          m_ack  [2];
   bit          m_rstq [2];
   logic        m_we   [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wd   [2];
   logic [3:0]  m_be   [2];
   logic [31:0] m_mem  [2][1024];
   bit   [3:0]  m_kv   [2][1024];
   // {err, compare mask, data}
   logic [64:0] exp_q  [2][$];

   logic [31:0] ma;
   logic [31:0] mmask;
   int          mwi;
   bit          mbad;

   always @(posedge clk) begin
      e++;
      started = 1'b1;
      for (int d = 0; d < 2; d++) begin
         m_ack[d]  = 1'b0;
         m_rstq[d] = 1'b0;
         if (!rst[d]) begin
            m_pend[d] = 1'b0;
            m_rstq[d] = 1'b1;
         end else if (m_pend[d]) begin
            if (e == m_s[d] + WV[d] + 1) begin
               ma   = m_addr[d];
               mbad = (ma % 4 != 0) || (ma >= (32'd1 << (AW + 2)));
               mwi  = int'(ma / 4);
               m_ack[d] = 1'b1;
               if (mbad) begin
                  exp_q[d].push_back({1'b1, 32'hFFFF_FFFF, 32'h0});
               end else if (m_we[d]) begin
                  for (int i = 0; i < 4; i++) begin
                     if (m_be[d][i]) begin
                        m_mem[d][mwi][8*i +: 8] = m_wd[d][8*i +: 8];
                        m_kv[d][mwi][i] = 1'b1;
                     end
                  end
                  exp_q[d].push_back({1'b0, 32'hFFFF_FFFF, 32'h0});
               end else begin
                  mmask = {{8{m_kv[d][mwi][3]}}, {8{m_kv[d][mwi][2]}},
                           {8{m_kv[d][mwi][1]}}, {8{m_kv[d][mwi][0]}}};
                  exp_q[d].push_back({1'b0, mmask, m_mem[d][mwi]});
               end
            end else if (e == m_s[d] + WV[d] + 2) begin
               m_pend[d] = 1'b0;
            end
         end else if (req[d]) begin
            m_pend[d] = 1'b1;
            m_s[d]    = e;
            m_we[d]   = we[d];
            m_addr[d] = addr[d];
            m_wd[d]   = wdata[d];
            m_be[d]   = be[d];
         end
      end
   end

   // ---------------- scoreboard: per-cycle compare ----------------
   logic [64:0] x;
   always @(negedge clk) begin
      if (started) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("ack dut%0d edge%0d", d, e), 32'(ack[d]), 32'(m_ack[d]));
            chk($sformatf("busy dut%0d edge%0d", d, e), 32'(busy[d]), 32'(m_pend[d]));
            if (m_rstq[d]) begin
               chk($sformatf("rst_rdata dut%0d", d), rdata[d], 32'h0);
               chk($sformatf("rst_err dut%0d", d), 32'(err[d]), 32'h0);
            end
            if (m_ack[d] && exp_q[d].size() > 0) begin
               x = exp_q[d].pop_front();
               chk($sformatf("err dut%0d edge%0d", d, e), 32'(err[d]), 32'(x[64]));
               if (x[63:32] != 32'h0)
                  chk($sformatf("rdata dut%0d edge%0d", d, e),
                      rdata[d] & x[63:32], x[31:0] & x[63:32]);
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Presents one request, scrambles the inputs once it has been sampled,
   // and waits for ack (or aborts with a reset pulse when rst_at != 0).
   task automatic do_txn(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b, input int rst_at,
                         output logic [31:0] rd, output logic er, output int lat,
                         output bit got);
      int n;
      bit done;
      req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
      n = 0; done = 1'b0; got = 1'b0; lat = -1; rd = 32'h0; er = 1'b0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) begin
            req[d]   = 1'b0;
            we[d]    = 1'($urandom_range(0, 1));
            addr[d]  = $urandom;
            wdata[d] = $urandom;
            be[d]    = 4'($urandom_range(0, 15));
         end
         if (ack[d]) begin
            got = 1'b1; lat = n - 1; rd = rdata[d]; er = err[d]; done = 1'b1;
            @(posedge clk); #1;
         end else if (rst_at != 0 && n == rst_at) begin
            rst[d] = 1'b0;
         end else if (rst_at != 0 && n == rst_at + 1) begin
            rst[d] = 1'b1;
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL txn_timeout dut%0d: no ack within %0d cycles, ack required", d, n);
      end
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] rd;
   logic        er;
   int          lat;
   bit          got;
   int          ack_e [$];
   int          lows;

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0;
         addr[d] = 32'h0; wdata[d] = 32'h0; be[d] = 4'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy[0]), 32'h0);
      chk("reset ack", 32'(ack[0]), 32'h0);
      rst[0] = 1'b1; rst[1] = 1'b1;
      @(posedge clk); #1;

      // write then read, WAIT=2
      do_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat, got);
      chk("wr latency", 32'(lat), 32'd3);
      chk("wr rdata", rd, 32'h0);
      do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, got);
      chk("rd latency", 32'(lat), 32'd3);
      chk("rd rdata", rd, 32'hDEAD_BEEF);
      chk("rd err", 32'(er), 32'h0);

      // byte enables
      do_txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, rd, er, lat, got);
      do_txn(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0, rd, er, lat, got);
      do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, got);
      chk("be rdata", rd, 32'h11BB_33DD);

      // be=0 is a legal no-op write
      do_txn(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lat, got);
      chk("be0 err", 32'(er), 32'h0);
      chk("be0 got", 32'(got), 32'h1);

      // errors
      do_txn(0, 1'b1, 32'h22, 32'h5555_5555, 4'hF, 0, rd, er, lat, got);
      chk("misalign err", 32'(er), 32'h1);
      chk("misalign rdata", rd, 32'h0);
      do_txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, rd, er, lat, got);
      chk("range err", 32'(er), 32'h1);
      chk("range rdata", rd, 32'h0);
      do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, got);
      chk("word20 kept", rd, 32'h11BB_33DD);

      // reset mid-transaction
      do_txn(0, 1'b1, 32'h30, 32'h0, 4'hF, 0, rd, er, lat, got);
      do_txn(0, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 1, rd, er, lat, got);
      chk("abort no ack", 32'(got), 32'h0);
      chk("abort busy", 32'(busy[0]), 32'h0);
      repeat (4) @(posedge clk);
      #1;
      do_txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat, got);
      chk("abort word30", rd, 32'h0);

      // inputs scrambled after sampling must not matter
      do_txn(0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 0, rd, er, lat, got);
      do_txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat, got);
      chk("captured inputs", rd, 32'h1234_5678);

      // back-to-back, WAIT=0
      do_txn(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat, got);
      chk("w0 latency", 32'(lat), 32'd1);
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10; be[1] = 4'hF;
      lows = 0;
      for (int k = 0; k < 20 && ack_e.size() < 2; k++) begin
         @(posedge clk); #1;
         if (ack_e.size() == 1 && !busy[1]) lows++;
         if (ack[1]) begin
            ack_e.push_back(e);
            chk("b2b rdata", rdata[1], 32'hDEAD_BEEF);
            if (ack_e.size() == 2) req[1] = 1'b0;
         end
      end
      chk("b2b acks", 32'(ack_e.size()), 32'd2);
      if (ack_e.size() == 2) chk("b2b spacing", 32'(ack_e[1] - ack_e[0]), 32'd3);
      chk("b2b idle cycles", 32'(lows), 32'd1);
      repeat (2) @(posedge clk);
      #1;

      // randomized traffic on both instances
      for (int d = 0; d < 2; d++) begin
         repeat (60) begin
            int kind;
            int ra;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            if (kind == 0)
               a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else if (kind == 1)
               a = (32'($urandom_range(0, 1023)) << 2) | (32'h1 << $urandom_range(12, 31));
            else if (kind == 2)
               a = 32'($urandom_range(16, 1023)) << 2;
            else
               a = 32'($urandom_range(0, 15)) << 2;
            ra = ($urandom_range(0, 9) == 0) ? $urandom_range(1, WV[d] + 1) : 0;
            do_txn(d, 1'($urandom_range(0, 1)), a, $urandom,
                   4'($urandom_range(0, 15)), ra, rd, er, lat, got);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
      end

      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, completion required");
      $fatal(1, "watchdog");
   end

endmodule
